// File: rtl/vga_line_fetcher_if.sv
// Burst bus between the line fetcher and the SDRAM burst master.
// master = the fetcher (issues requests), slave = the SDRAM burst engine.
interface vga_line_fetcher_if #(
  parameter int ADDR_W = 25
);
  logic              burst_req;
  logic [ADDR_W-1:0] burst_addr;
  logic              mem_ready;
  logic [31:0]       mem_data;
  logic              burst_finished;

  modport master (
    output burst_req, burst_addr,
    input  mem_ready, mem_data, burst_finished
  );

  modport slave (
    input  burst_req, burst_addr,
    output mem_ready, mem_data, burst_finished
  );
endinterface

// File: rtl/vga_line_fetcher.sv
// Double-buffered scanline prefetcher: one SDRAM burst per line into the idle bank,
// display reads from the other. Optional underrun counter under LINE_FETCH_STATS_EN.
module vga_line_fetcher #(
  parameter int LINE_WORDS  = 640,
  parameter int FRAME_LINES = 480,
  parameter int ADDR_W      = 25
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] frame_base,
  vga_line_fetcher_if.master bus,
  input  logic [9:0]        pix_x,
  output logic [31:0]       pix_data,
  output logic              line_valid,
  output logic              underrun,
  output logic [15:0]       underrun_count
);

  localparam int CW = $clog2(LINE_WORDS + 1);
  localparam int NW = $clog2(FRAME_LINES + 1);
  localparam int RW = $clog2(2 * LINE_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base, pend_base, addr_q;
  logic [NW-1:0]     next_line;
  logic [CW-1:0]     wr_count;
  logic              disp_bank, wr_valid, pending_frame;

  logic              busy, frame_go, line_more, wr_en, rd_in_range, rd_ok;
  logic [ADDR_W-1:0] go_base, line_addr;
  logic [RW-1:0]     wr_addr, rd_addr;
  logic [31:0]       rd_word;
  logic [31:0]       mem [0:2*LINE_WORDS-1];

  assign busy        = (state == S_REQ) || (state == S_FILL);
  assign frame_go    = frame_start || pending_frame;
  assign go_base     = frame_start ? frame_base : pend_base;
  assign line_more   = 32'(next_line) < FRAME_LINES;
  assign line_addr   = base + ADDR_W'(next_line) * ADDR_W'(LINE_WORDS);
  assign wr_en       = busy && bus.mem_ready && (32'(wr_count) < LINE_WORDS);

  assign bus.burst_req  = (state == S_REQ);
  assign bus.burst_addr = addr_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      base          <= '0;
      pend_base     <= '0;
      next_line     <= NW'(FRAME_LINES);
      wr_count      <= '0;
      disp_bank     <= 1'b0;
      wr_valid      <= 1'b0;
      line_valid    <= 1'b0;
      pending_frame <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_go) begin
            base          <= go_base;
            addr_q        <= go_base;
            next_line     <= '0;
            wr_valid      <= 1'b0;
            line_valid    <= 1'b0;
            pending_frame <= 1'b0;
            wr_count      <= '0;
            state         <= S_REQ;
          end else if (line_start) begin
            if (wr_valid) begin
              disp_bank  <= ~disp_bank;
              line_valid <= 1'b1;
              wr_valid   <= 1'b0;
            end else begin
              line_valid <= 1'b0;
            end
            if (line_more) begin
              addr_q   <= line_addr;
              wr_count <= '0;
              state    <= S_REQ;
            end
          end
        end
        S_REQ, S_FILL: begin
          // Words past the line end are dropped and the counter parks at LINE_WORDS.
          if (wr_en) wr_count <= wr_count + CW'(1);
          if (state == S_REQ && bus.mem_ready) state <= S_FILL;
          if (state == S_FILL && bus.burst_finished) begin
            wr_valid  <= 1'b1;
            next_line <= next_line + NW'(1);
            state     <= S_IDLE;
          end
          // Display keeps repeating the old line; the burst is never aborted.
          if (line_start) underrun <= 1'b1;
          if (frame_start) begin
            pending_frame <= 1'b1;
            pend_base     <= frame_base;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line storage: bank b occupies words [b*LINE_WORDS, (b+1)*LINE_WORDS).
  assign wr_addr     = (disp_bank ? '0 : RW'(LINE_WORDS)) + RW'(wr_count);
  assign rd_in_range = 32'(pix_x) < LINE_WORDS;
  assign rd_addr     = rd_in_range ? ((disp_bank ? RW'(LINE_WORDS) : '0) + RW'(pix_x)) : '0;

  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= bus.mem_data;
    rd_word <= mem[rd_addr];
  end

  always_ff @(posedge Clk) begin
    if (Reset) rd_ok <= 1'b0;
    else       rd_ok <= line_valid && rd_in_range;
  end

  assign pix_data = rd_ok ? rd_word : 32'h0;

`ifdef LINE_FETCH_STATS_EN
  logic [15:0] und_cnt;
  always_ff @(posedge Clk) begin
    if (Reset) und_cnt <= '0;
    else if (busy && line_start && und_cnt != 16'hFFFF) und_cnt <= und_cnt + 16'd1;
  end
  assign underrun_count = und_cnt;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Scoreboard bench for vga_line_fetcher: stimulus queues expected burst addresses,
// pixel reads and underrun counts; a negedge monitor pops and compares them.
module tb_vga_line_fetcher;
  localparam int LW = 640;
  localparam int FL = 480;
  localparam int AW = 25;
`ifdef LINE_FETCH_STATS_EN
  localparam logic [15:0] EXP_UND = 16'd1;
`else
  localparam logic [15:0] EXP_UND = 16'd0;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          line_start = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic [9:0]    pix_x = '0;
  logic [31:0]   pix_data;
  logic          line_valid, underrun;
  logic [15:0]   underrun_count;

  vga_line_fetcher_if #(.ADDR_W(AW)) bus ();

  vga_line_fetcher #(.LINE_WORDS(LW), .FRAME_LINES(FL), .ADDR_W(AW)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .line_start(line_start),
    .frame_base(frame_base), .bus(bus), .pix_x(pix_x), .pix_data(pix_data),
    .line_valid(line_valid), .underrun(underrun), .underrun_count(underrun_count)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [AW-1:0] addr_q[$];
  logic [31:0]   rd_q[$];
  logic [15:0]   und_q[$];
  logic          req_prev = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic          rd_tag = 1'b0;
  logic          rd_tag_d = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(posedge Clk) rd_tag_d <= rd_tag;

  // Monitor
  always @(negedge Clk) begin
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    logic [15:0]   eu;
    if (!Reset) begin
      if (bus.burst_req && !req_prev) begin
        check("req_expected", 64'(addr_q.size() != 0), 64'd1);
        if (addr_q.size() != 0) begin
          ea = addr_q.pop_front();
          check("burst_addr", bus.burst_addr, ea);
          cur_addr <= ea;
        end
      end
      if (bus.burst_finished) check("addr_hold", bus.burst_addr, cur_addr);
      if (underrun) begin
        check("underrun_expected", 64'(und_q.size() != 0), 64'd1);
        if (und_q.size() != 0) begin
          eu = und_q.pop_front();
          check("underrun_count_at_pulse", underrun_count, eu);
        end
      end
      if (rd_tag_d && rd_q.size() != 0) begin
        ed = rd_q.pop_front();
        check("pix_data", pix_data, ed);
      end
    end
    req_prev <= bus.burst_req;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse(input logic fs, input logic ls);
    frame_start = fs;
    line_start  = ls;
    tick();
    frame_start = 1'b0;
    line_start  = 1'b0;
  endtask

  task automatic rd(input logic [9:0] x, input logic [31:0] e);
    pix_x  = x;
    rd_tag = 1'b1;
    rd_q.push_back(e);
    tick();
    rd_tag = 1'b0;
  endtask

  // Bench burst master: n data words plus `extra` surplus words, burst_finished on the last.
  task automatic fill(input int n, input int extra, input logic [31:0] v0,
                      input int ls_at, input int fs_at);
    int t = 0;
    while (!bus.burst_req && t < 200) begin tick(); t++; end
    check("req_seen", bus.burst_req, 1'b1);
    for (int i = 0; i < n + extra; i++) begin
      bus.mem_ready      = 1'b1;
      bus.mem_data       = (i < n) ? v0 + 32'(i) : 32'hDEAD_0000 + 32'(i);
      bus.burst_finished = (i == n + extra - 1);
      line_start         = (i == ls_at);
      frame_start        = (i == fs_at);
      tick();
    end
    bus.mem_ready      = 1'b0;
    bus.burst_finished = 1'b0;
    line_start         = 1'b0;
    frame_start        = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.mem_ready = 1'b0; bus.mem_data = '0; bus.burst_finished = 1'b0;
    repeat (3) tick();
    check("rst_burst_req", bus.burst_req, 1'b0);
    check("rst_burst_addr", bus.burst_addr, '0);
    check("rst_line_valid", line_valid, 1'b0);
    check("rst_pix_data", pix_data, 32'h0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_underrun_count", underrun_count, 16'h0);
    Reset = 1'b0;
    tick();

    // First line of a frame at 0x1000
    frame_base = 25'h1000;
    addr_q.push_back(25'h1000);
    pulse(1'b1, 1'b0);
    rd(10'd5, 32'h0);
    check("lv_before_first_line", line_valid, 1'b0);
    fill(LW, 0, 32'hA000, -1, -1);
    addr_q.push_back(25'h1280);
    pulse(1'b0, 1'b1);
    check("lv_after_swap", line_valid, 1'b1);
    rd(10'd5, 32'hA005);
    rd(10'd0, 32'hA000);
    rd(10'd639, 32'hA27F);
    rd(10'd640, 32'h0);
    rd(10'd1023, 32'h0);

    // Underrun at word 300, plus surplus words past the line end
    und_q.push_back(EXP_UND);
    fork
      fill(LW, 4, 32'hB000, 300, -1);
      begin repeat (400) tick(); rd(10'd5, 32'hA005); end
    join
    check("lv_after_underrun", line_valid, 1'b1);
    for (int i = 0; i < 4; i++) rd(10'(i), 32'hA000 + 32'(i));
    rd(10'd639, 32'hA27F);
    check("underrun_count_1", underrun_count, EXP_UND);
    addr_q.push_back(25'h1500);
    pulse(1'b0, 1'b1);
    check("lv_late_swap", line_valid, 1'b1);
    rd(10'd5, 32'hB005);
    rd(10'd0, 32'hB000);
    rd(10'd639, 32'hB27F);

    // frame_start during FILL is deferred until the burst completes
    frame_base = 25'h2000;
    addr_q.push_back(25'h2000);
    fill(LW, 0, 32'hC000, -1, 100);
    repeat (3) tick();
    check("lv_after_pending_frame", line_valid, 1'b0);
    rd(10'd5, 32'h0);
    fill(4, 0, 32'hD000, -1, -1);

    // frame_start and line_start together: frame path only, no swap
    frame_base = 25'h3000;
    addr_q.push_back(25'h3000);
    pulse(1'b1, 1'b1);
    check("lv_frame_wins", line_valid, 1'b0);
    rd(10'd0, 32'h0);

    // Full frame: short bursts keep the sweep inside the cycle budget
    for (int n = 0; n < FL; n++) begin
      fill(2, 0, 32'h5000 + 32'(n), -1, -1);
      if (n + 1 < FL) addr_q.push_back(AW'(32'h3000 + (n + 1) * LW));
      pulse(1'b0, 1'b1);
      check("lv_sweep", line_valid, 1'b1);
      rd(10'd0, 32'h5000 + 32'(n));
    end
    repeat (20) tick();
    check("no_req_after_last_line", bus.burst_req, 1'b0);
    check("addr_queue_drained", 64'(addr_q.size()), 64'd0);

    // Stray master strobes in IDLE are ignored
    bus.mem_ready = 1'b1; bus.burst_finished = 1'b1; bus.mem_data = 32'hFFFF_FFFF;
    repeat (3) tick();
    bus.mem_ready = 1'b0; bus.burst_finished = 1'b0;
    check("stray_no_req", bus.burst_req, 1'b0);
    check("stray_lv", line_valid, 1'b1);
    rd(10'd0, 32'h5000 + 32'(FL - 1));
    tick();

    check("underrun_queue_drained", 64'(und_q.size()), 64'd0);
    check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
    check("underrun_count_final", underrun_count, EXP_UND);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
